fakeregfile_128x64_ctrl: RTL and testbench
==========================================

// Module: fakeregfile_128x64_ctrl
// PURPOSE
//  Request front-end for the 128x64 register-file macro: accepts read/write requests on a
//  valid/ready port and drives the macro's ce/we/addr/wd pins. Captures the macro read data
//  one cycle after each access and returns one response per request through a response FIFO.
//  Macro pins are driven only on accepted requests, so the macro never sees a spurious access.
// PARAMETERS
//  BITS        64   data width; must match macro
//  ADDR_WIDTH  7    address width; must match macro (128 words)
//  RSP_DEPTH   3    response FIFO entries; min 2; >=3 gives 1 req/cycle sustained
// PORTS
//  clk          in   1           clock; macro shares this clock
//  reset        in   1           asynchronous, active-high reset
//  req_valid    in   1           request valid
//  req_ready    out  1           request accepted when req_valid & req_ready at posedge
//  req_we       in   1           1 = write, 0 = read
//  req_addr     in   ADDR_WIDTH  word address
//  req_wdata    in   BITS        write data
//  rsp_valid    out  1           response valid
//  rsp_ready    in   1           response consumed when rsp_valid & rsp_ready at posedge
//  rsp_we       out  1           echo of req_we for this response
//  rsp_data     out  BITS        word contents before this request's write
//  mem_ce_o     out  1           to macro ce_in
//  mem_we_o     out  1           to macro we_in
//  mem_addr_o   out  ADDR_WIDTH  to macro addr_in
//  mem_wd_o     out  BITS        to macro wd_in
//  mem_rd_i     in   BITS        from macro rd_out
// BEHAVIOUR
//  - fire = req_valid & req_ready. mem_ce_o = fire; mem_we_o = fire & req_we (combinational).
//  - mem_addr_o = req_addr and mem_wd_o = req_wdata, passed through unconditionally.
//  - Macro semantics: a write ORs wd into the word. rd_out the next cycle holds the
//    pre-write word. Reads and writes both produce a response.
//  - pend_q/pend_we_q are registered fire/req_we. While pend_q=1, mem_rd_i is valid. At that
//    posedge, {pend_we_q, mem_rd_i} is pushed into the FIFO.
//  - mem_rd_i is ignored when pend_q=0; the macro drives X then.
//  - Latency: request accepted at edge E -> rsp_valid high from the cycle after edge E+1
//    (2 cycles). With an empty FIFO, no bypass is used.
//  - Credit: req_ready = !reset & (count + pend_q < RSP_DEPTH).
//    A same-cycle pop earns no credit, so there is no rsp_ready->req_ready combinational path.
//  - FIFO: in-order; push and pop in the same cycle leave count unchanged.
//    Pointers wrap modulo RSP_DEPTH. By the credit rule, a push never meets a full FIFO.
//  - rsp_valid = (count != 0); rsp_we/rsp_data = head entry. These outputs are stable while
//    rsp_valid & !rsp_ready.
//  - Ordering: responses are returned strictly in request order. Back-to-back same-address
//    accesses see earlier writes, because macro accesses are sequential.
//  - Reset (async assert): pend_q=0, count=0, pointers=0. Then rsp_valid=0 and req_ready=0,
//    so mem_ce_o=0 and mem_we_o=0.
//  - Reset mid-operation: in-flight and queued responses are discarded. Macro contents are
//    untouched (the macro has no reset). req_ready rises in the first cycle after deassertion.
//  - Simulation assertion: flag X on req_we or req_addr when req_valid=1.
// TESTING
//  - Bench pre-loads macro mem to 0 via backdoor before each scenario.
//  - Reset: assert reset mid-cycle -> req_ready, rsp_valid, mem_ce_o drop to 0 immediately.
//    After release, req_ready=1 on the next cycle.
//  - OR-write: write 0x0F to addr 5, write 0xF0 to addr 5, read addr 5.
//    -> responses in order: (we=1, data 0x00), (we=1, data 0x0F), (we=0, data 0xFF).
//    The first response appears 2 cycles after acceptance.
//  - Throughput: RSP_DEPTH=3, rsp_ready=1, 16 back-to-back reads of addr 0..15 (preloaded
//    with data=addr) -> req_ready stays 1; 16 responses on consecutive cycles with data 0..15.
//  - Backpressure: rsp_ready=0, issue 5 reads -> exactly 3 accepted, then req_ready=0 and
//    mem_ce_o=0. rsp_data holds the first value. Release rsp_ready -> all 5 responses return
//    in order, none lost or duplicated.
//  - Reset with 2 responses queued and 1 pending -> after reset, rsp_valid=0.
//    A new read of addr 5 returns the value written before reset.
//  - Idle: req_valid=0 for 10 cycles -> mem_ce_o=0 throughout; no response is generated even
//    though mem_rd_i=X.

Source files
------------

// File: rtl/fakeregfile_128x64_ctrl.sv
// fakeregfile_128x64_ctrl
//   Request front-end for the 128x64 register-file macro. Requests arrive on a
//   valid/ready port. Each accepted request drives exactly one macro access
//   (ce/we/addr/wd). The macro read data is captured one cycle later and queued as a
//   response. Every request, read or write, gets exactly one response, and responses
//   come back in request order.
//
// Ports
//   clk, reset            clock shared with the macro; asynchronous active-high reset
//   req_valid/req_ready   request handshake (fire = req_valid & req_ready)
//   req_we/addr/wdata     request fields
//   rsp_valid/rsp_ready   response handshake
//   rsp_we/rsp_data       echoed write flag; word contents before this request's write
//   mem_ce_o/we_o         macro strobes, asserted only on accepted requests
//   mem_addr_o/wd_o       macro address/data, passed straight through
//   mem_rd_i              macro read data, meaningful one cycle after an access
module fakeregfile_128x64_ctrl #(
  parameter int unsigned BITS       = 64,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned RSP_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BITS-1:0]       req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [BITS-1:0]       rsp_data,
  output logic                  mem_ce_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [BITS-1:0]       mem_wd_o,
  input  logic [BITS-1:0]       mem_rd_i
);

  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  // One bit wider than the count so count + pend_q cannot overflow.
  typedef logic [CNT_W:0]   credit_t;

  localparam ptr_t    PTR_LAST = ptr_t'(RSP_DEPTH - 1);
  localparam credit_t DEPTH_C  = credit_t'(RSP_DEPTH);

  logic            fire;
  logic            push;
  logic            pop;
  logic            pend_q;
  logic            pend_we_q;
  ptr_t            wr_ptr;
  ptr_t            rd_ptr;
  cnt_t            count;
  credit_t         used;
  logic [BITS:0]   fifo_q [RSP_DEPTH];

  // Credit counts queued entries plus the access whose data is still in flight.
  // A pop in the same cycle earns no credit, so rsp_ready never reaches req_ready
  // combinationally.
  always_comb begin
    used      = credit_t'(count) + credit_t'(pend_q);
    req_ready = !reset && (used < DEPTH_C);
    fire      = req_valid && req_ready;
  end

  always_comb begin
    mem_ce_o   = fire;
    mem_we_o   = fire && req_we;
    mem_addr_o = req_addr;
    mem_wd_o   = req_wdata;
  end

  // Macro read data is valid exactly in the cycle after an access.
  assign push = pend_q;
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q    <= 1'b0;
      pend_we_q <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      pend_q    <= fire;
      pend_we_q <= fire && req_we;
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + ptr_t'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed through count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= {pend_we_q, mem_rd_i};
    end
  end

  always_comb begin
    rsp_valid = (count != '0);
    {rsp_we, rsp_data} = fifo_q[rd_ptr];
  end

  a_req_known: assert property (@(posedge clk) disable iff (reset)
    req_valid |-> !$isunknown({req_we, req_addr}));

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (credit_t'(count) == DEPTH_C)));

endmodule

// File: tb/tb_fakeregfile_128x64_ctrl.sv
module tb_fakeregfile_128x64_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [6:0]  req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_we;
  logic [63:0] rsp_data;
  logic        mem_ce_o;
  logic        mem_we_o;
  logic [6:0]  mem_addr_o;
  logic [63:0] mem_wd_o;
  logic [63:0] mem_rd_i;

  int checks;
  int errors;

  fakeregfile_128x64_ctrl #(
    .BITS(64),
    .ADDR_WIDTH(7),
    .RSP_DEPTH(3)
  ) dut (
    .clk(clk),
    .reset(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_we(rsp_we),
    .rsp_data(rsp_data),
    .mem_ce_o(mem_ce_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_wd_o(mem_wd_o),
    .mem_rd_i(mem_rd_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Macro model: OR-write, next-cycle read data holds the pre-write word, X otherwise.
  logic [63:0] macro_mem [128];
  logic [63:0] macro_rd_q;
  logic        macro_rd_vld;

  always @(posedge clk) begin
    if (mem_ce_o) begin
      macro_rd_q <= macro_mem[mem_addr_o];
      if (mem_we_o) macro_mem[mem_addr_o] = macro_mem[mem_addr_o] | mem_wd_o;
    end
    macro_rd_vld <= mem_ce_o;
  end

  assign mem_rd_i = macro_rd_vld ? macro_rd_q : 'x;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload_zero();
    for (int i = 0; i < 128; i++) macro_mem[i] = '0;
  endtask

  task automatic test_reset();
    preload_zero();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 7'd0; req_wdata = 64'h1;
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (mem_ce_o !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b expected 0", mem_ce_o); end
    checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", mem_we_o); end
    tick(); tick();
    req_we = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", req_ready); end
    tick(); tick(); tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL busy_rsp_valid: got %b expected 1", rsp_valid); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b expected 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (mem_ce_o !== 1'b0) begin errors++; $display("FAIL midreset_ce: got %b expected 0", mem_ce_o); end
    req_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrelease_ready: got %b expected 1", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrelease_rsp_valid: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_or_write();
    preload_zero();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'd5; req_wdata = 64'h0F;
    #1;
    checks++; if (mem_ce_o !== 1'b1) begin errors++; $display("FAIL orw_ce: got %b expected 1", mem_ce_o); end
    checks++; if (mem_we_o !== 1'b1) begin errors++; $display("FAIL orw_we: got %b expected 1", mem_we_o); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL orw_latency: got %b expected 0", rsp_valid); end
    req_wdata = 64'hF0;
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL orw_rsp0_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_we !== 1'b1) begin errors++; $display("FAIL orw_rsp0_we: got %b expected 1", rsp_we); end
    checks++; if (rsp_data !== 64'h00) begin errors++; $display("FAIL orw_rsp0_data: got %h expected 0", rsp_data); end
    req_we = 1'b0; req_wdata = 64'h0;
    tick();
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b1) begin errors++; $display("FAIL orw_rsp1_we: got v%b we%b expected v1 we1", rsp_valid, rsp_we); end
    checks++; if (rsp_data !== 64'h0F) begin errors++; $display("FAIL orw_rsp1_data: got %h expected 0f", rsp_data); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b0) begin errors++; $display("FAIL orw_rsp2_we: got v%b we%b expected v1 we0", rsp_valid, rsp_we); end
    checks++; if (rsp_data !== 64'hFF) begin errors++; $display("FAIL orw_rsp2_data: got %h expected ff", rsp_data); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL orw_drain: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    preload_zero();
    for (int i = 0; i < 16; i++) macro_mem[i] = 64'(i);
    rsp_ready = 1'b1; req_we = 1'b0; req_wdata = '0;
    for (int k = 0; k < 18; k++) begin
      req_valid = (k < 16);
      req_addr  = 7'(k);
      #1;
      if (k < 16) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, req_ready); end
      end
      if (k >= 2) begin
        exp = 64'(k - 2);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
          errors++; $display("FAIL b2b_rsp[%0d]: got v%b %h expected v1 %h", k, rsp_valid, rsp_data, exp);
        end
      end
      tick();
    end
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    int issued;
    int got;
    int extra;
    logic [63:0] exp;
    preload_zero();
    for (int i = 0; i < 5; i++) macro_mem[i] = 64'h100 + 64'(i);
    rsp_ready = 1'b0; req_we = 1'b0; req_wdata = '0;
    issued = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1;
      req_addr  = 7'(issued);
      #1;
      if (req_ready) issued++;
      if (c >= 3) begin
        checks++; if (req_ready !== 1'b0 || mem_ce_o !== 1'b0) begin
          errors++; $display("FAIL bp_stall[%0d]: got ready%b ce%b expected 0 0", c, req_ready, mem_ce_o);
        end
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h100) begin
          errors++; $display("FAIL bp_hold[%0d]: got v%b %h expected v1 100", c, rsp_valid, rsp_data);
        end
      end
      tick();
    end
    checks++; if (issued !== 3) begin errors++; $display("FAIL bp_accepted: got %0d expected 3", issued); end
    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      req_valid = (issued < 5);
      req_addr  = 7'(issued);
      #1;
      if (rsp_valid) begin
        exp = 64'h100 + 64'(got);
        checks++; if (rsp_data !== exp) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", got, rsp_data, exp); end
        got++;
      end
      if (req_valid && req_ready) issued++;
      tick();
    end
    req_valid = 1'b0;
    checks++; if (got !== 5) begin errors++; $display("FAIL bp_count: got %0d expected 5", got); end
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid) extra++;
      tick();
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL bp_dup: got %0d extra expected 0", extra); end
  endtask

  task automatic test_reset_inflight();
    preload_zero();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'd5; req_wdata = 64'hAB;
    tick();
    req_we = 1'b0; req_addr = 7'd1; req_wdata = '0;
    tick();
    req_addr = 7'd2;
    tick();
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rif_queued: got %b expected 1", rsp_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL rif_reset: got v%b ready%b expected 0 0", rsp_valid, req_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rif_release_ready: got %b expected 1", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rif_discard: got %b expected 0", rsp_valid); end
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd5;
    tick();
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rif_latency: got %b expected 0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_data !== 64'hAB) begin
      errors++; $display("FAIL rif_read5: got v%b we%b %h expected v1 we0 ab", rsp_valid, rsp_we, rsp_data);
    end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rif_drain: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_idle();
    preload_zero();
    rsp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'bx; req_addr = 'x; req_wdata = 'x;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (mem_ce_o !== 1'b0) begin errors++; $display("FAIL idle_ce[%0d]: got %b expected 0", c, mem_ce_o); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_rsp[%0d]: got %b expected 0", c, rsp_valid); end
      tick();
    end
    req_we = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_or_write();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
